ddr_lane_scheduler: RTL and testbench
=====================================

// Module: ddr_lane_scheduler
// PURPOSE
//  Game sequencer for the 4 DDR arrow lanes (left, up, down, right). Spawns arrows at SPAWN_Y on a pseudo-random lane.
//  Moves active arrows up SPEED px per frame and judges debounced button presses against a target window.
//  Keeps score and miss count; ends the game at MAX_MISS. Sits between the debouncers/frame strobe and the paint logic.
// PARAMETERS
//  CORDW         10     screen coordinate width
//  SPAWN_Y       480    y loaded on spawn (just below visible area)
//  TOP_Y         3      arrow leaving above TOP_Y = miss
//  SPEED         7      px moved per frame, must satisfy 0 < SPEED < SPAWN_Y
//  TARGET_Y      40     y of the judge line
//  WINDOW        10     hit if |y - TARGET_Y| <= WINDOW
//  SPAWN_FRAMES  30     frames between spawn attempts, >= 1
//  MAX_MISS      8      miss count that ends the game
//  SCORE_W       8      score width (saturating)
//  LFSR_SEED     8'hA5  nonzero LFSR reset value
// PORTS
//  clk_i          in   1          pixel clock
//  reset_ni       in   1          async active-low reset
//  frame_i        in   1          1-cycle pulse per frame (start of vblank)
//  start_i        in   1          1-cycle pulse: start or restart game
//  press_i        in   4          1-cycle debounced presses [0]=L [1]=U [2]=D [3]=R
//  lane_active_o  out  4          lane holds a live arrow
//  lane_y_o       out  4*CORDW    packed arrow y, lane n at [n*CORDW +: CORDW]
//  hit_o          out  4          1-cycle pulse per lane judged a hit
//  miss_o         out  4          1-cycle pulse per lane miss (late or bad press)
//  score_o        out  SCORE_W    hit count, saturates at all-ones
//  miss_cnt_o     out  4          misses so far, saturates at MAX_MISS
//  state_o        out  2          ddr_pkg::game_state_e
// BEHAVIOUR
//  Reset (async, reset_ni=0): state IDLE; all lanes inactive; every y = SPAWN_Y; hit_o/miss_o = 0.
//    Also score=0, miss_cnt=0, frame counter 0, LFSR = LFSR_SEED. Release takes effect on next clk edge.
//  All outputs registered. Pulses are visible the cycle after the triggering input.
//  FSM:
//    IDLE -start_i-> PLAY: clears score, miss_cnt, lanes and frame counter.
//    PLAY -(miss_cnt_next >= MAX_MISS)-> OVER
//    OVER -start_i-> PLAY: same clears as IDLE->PLAY.
//    start_i is ignored in PLAY. Outside PLAY: no movement, spawns or judging; pulses stay 0.
//  Each frame_i in PLAY: the LFSR steps (x^8+x^6+x^5+x^4+1) and the frame counter increments.
//    Frame counter wraps at SPAWN_FRAMES-1. The wrap frame is a spawn attempt.
//  Spawn attempt: lane = lfsr[1:0] (post-step value).
//    If the lane was inactive at start of the cycle: active=1, y=SPAWN_Y.
//    Otherwise the attempt is dropped with no retry.
//  Movement on frame_i, per active lane, using unsigned CORDW math:
//    if y < TOP_Y+SPEED: lane goes inactive, y=SPAWN_Y, miss_o[n] pulses.
//    else y -= SPEED.
//  Press on an active lane, judged on the pre-move y: hit if |y-TARGET_Y| <= WINDOW, else miss.
//    Either way the lane goes inactive with y=SPAWN_Y. Press on an inactive lane is ignored.
//  Simultaneous events:
//    press+frame on same lane: press wins, no move, no late-miss.
//    Several lanes in one cycle: each is judged independently.
//    score += popcount(hit), miss_cnt += popcount(miss), both saturating.
//    A lane freed this cycle is not respawned this cycle.
//  Reaching MAX_MISS mid-frame: all pulses for that cycle still appear, then state=OVER.
//    Lanes freeze with their y held.
// STRUCTURE
//  ddr_pkg:
//    typedef enum logic [1:0] {GAME_IDLE=0, GAME_PLAY=1, GAME_OVER=2} game_state_e
//    localparam NUM_LANES=4; localparam CORDW=10
//  Sub-module ddr_lfsr8: 8-bit Fibonacci LFSR with step_i, SEED parameter, async reset.
//  Frame counter reuses counter_up. Per-lane logic is a generate loop.
// TESTING (defaults; LFSR_SEED forced so the first spawn lands in lane 0)
//  1. reset_ni=0 mid-PLAY with 2 lanes active -> same cycle: lane_active_o=0, score_o=0, state_o=IDLE.
//  2. start_i, then 30 frame_i -> lane 0 active at y=480; each further frame y -= 7 (473, 466, ...).
//  3. Press L when y=39 -> hit_o=4'b0001 next cycle, score_o=1, lane 0 inactive, y=480.
//  4. Press L when y=60 -> miss_o[0], miss_cnt_o=1. Press U with lane 1 idle -> no pulse.
//  5. No presses: y=11 -> 4 -> on next frame lane inactive, miss_o[0]=1. After 8 misses state_o=OVER.
//     start_i -> PLAY with score=0 and miss_cnt=0.
//  6. Press L and U in the same cycle both in window, one frame_i coincident -> hit_o=4'b0011, score += 2.
//     No movement for those lanes.

Source files
------------

// File: rtl/ddr_lane_scheduler_pkg.sv
// Shared types and constants for the DDR arrow-lane game sequencer.
package ddr_lane_scheduler_pkg;

  typedef enum logic [1:0] {
    GAME_IDLE = 2'd0,
    GAME_PLAY = 2'd1,
    GAME_OVER = 2'd2
  } game_state_e;

  localparam int NUM_LANES = 4;
  localparam int CORDW     = 10;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/ddr_lane_scheduler_if.sv
// Bus between frame/button sources, the lane scheduler and the paint logic.
interface ddr_lane_scheduler_if #(
  parameter int CORDW   = 10,
  parameter int SCORE_W = 8
);
  import ddr_lane_scheduler_pkg::*;

  // No valid/ready here: frame_i, start_i and press_i are single-cycle
  // strobes that are always accepted; hit_o/miss_o answer one cycle later,
  // and every other output is a registered level.
  logic                 frame_i;
  logic                 start_i;
  logic [3:0]           press_i;
  logic [3:0]           lane_active_o;
  logic [4*CORDW-1:0]   lane_y_o;
  logic [3:0]           hit_o;
  logic [3:0]           miss_o;
  logic [SCORE_W-1:0]   score_o;
  logic [3:0]           miss_cnt_o;
  game_state_e          state_o;

  modport master (
    output frame_i, start_i, press_i,
    input  lane_active_o, lane_y_o, hit_o, miss_o, score_o, miss_cnt_o, state_o
  );

  modport slave (
    input  frame_i, start_i, press_i,
    output lane_active_o, lane_y_o, hit_o, miss_o, score_o, miss_cnt_o, state_o
  );

endinterface

// File: rtl/ddr_lane_scheduler_lfsr.sv
// Small sequencing primitives: the spawn-lane LFSR and a wrapping frame counter.
module ddr_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       step_i,
  output logic [1:0] lane_o
);
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // x^8+x^6+x^5+x^4+1, shifting toward the MSB
  always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)   lfsr_q <= SEED;
    else if (step_i) lfsr_q <= lfsr_d;
  end

  // Post-step value, so a spawn on a stepping frame sees the new state.
  assign lane_o = lfsr_d[1:0];
endmodule

module counter_up #(
  parameter int W   = 5,
  parameter int MAX = 29
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic wrap_o
);
  logic [W-1:0] cnt_q;

  assign wrap_o = en_i && (cnt_q == W'(MAX));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    cnt_q <= '0;
    else if (clr_i)   cnt_q <= '0;
    else if (en_i)    cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/ddr_lane_scheduler.sv
// Game sequencer for four DDR arrow lanes: spawn, scroll, judge presses, keep
// score and misses, and end the game once the miss budget is spent.
module ddr_lane_scheduler #(
  parameter int         CORDW        = 10,
  parameter int         SPAWN_Y      = 480,
  parameter int         TOP_Y        = 3,
  parameter int         SPEED        = 7,
  parameter int         TARGET_Y     = 40,
  parameter int         WINDOW       = 10,
  parameter int         SPAWN_FRAMES = 30,
  parameter int         MAX_MISS     = 8,
  parameter int         SCORE_W      = 8,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  ddr_lane_scheduler_if.slave   bus
);
  import ddr_lane_scheduler_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int FCW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

  localparam logic [CORDW-1:0] Y_SPAWN = CORDW'(SPAWN_Y);
  localparam logic [CORDW-1:0] Y_LATE  = CORDW'(TOP_Y + SPEED);
  localparam logic [CORDW-1:0] Y_STEP  = CORDW'(SPEED);
  localparam logic [CORDW-1:0] Y_TGT   = CORDW'(TARGET_Y);
  localparam logic [CORDW-1:0] Y_WIN   = CORDW'(WINDOW);

  logic [1:0]           state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [3:0]           miss_cnt_q, miss_cnt_d;

  logic                 in_play;
  logic                 frame_play;
  logic                 restart;
  logic                 spawn_now;
  logic [1:0]           spawn_lane;
  logic [NUM_LANES-1:0] hit_d;
  logic [NUM_LANES-1:0] miss_d;

  assign in_play    = (state_q == ST_PLAY);
  assign frame_play = in_play && bus.frame_i;
  assign restart    = !in_play && bus.start_i;

  // spawn_now already includes frame_play through en_i.
  counter_up #(
    .W   (FCW),
    .MAX (SPAWN_FRAMES - 1)
  ) u_frame_cnt (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clr_i    (restart),
    .en_i     (frame_play),
    .wrap_o   (spawn_now)
  );

  ddr_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .step_i   (frame_play),
    .lane_o   (spawn_lane)
  );

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    logic             act_q, act_d;
    logic [CORDW-1:0] y_q, y_d;
    logic             hit_l, miss_l;
    logic             hit_q, miss_q;
    logic             in_win;

    always_comb in_win = (y_q >= Y_TGT) ? ((y_q - Y_TGT) <= Y_WIN)
                                        : ((Y_TGT - y_q) <= Y_WIN);

    // Press beats movement; spawning only considers lanes idle at cycle start.
    always_comb begin
      act_d  = act_q;
      y_d    = y_q;
      hit_l  = 1'b0;
      miss_l = 1'b0;
      if (restart) begin
        act_d = 1'b0;
        y_d   = Y_SPAWN;
      end else if (in_play) begin
        if (act_q && bus.press_i[n]) begin
          hit_l  = in_win;
          miss_l = !in_win;
          act_d  = 1'b0;
          y_d    = Y_SPAWN;
        end else if (act_q && bus.frame_i) begin
          if (y_q < Y_LATE) begin
            miss_l = 1'b1;
            act_d  = 1'b0;
            y_d    = Y_SPAWN;
          end else begin
            y_d = y_q - Y_STEP;
          end
        end else if (!act_q && spawn_now && (spawn_lane == 2'(n))) begin
          act_d = 1'b1;
          y_d   = Y_SPAWN;
        end
      end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        act_q  <= 1'b0;
        y_q    <= Y_SPAWN;
        hit_q  <= 1'b0;
        miss_q <= 1'b0;
      end else begin
        act_q  <= act_d;
        y_q    <= y_d;
        hit_q  <= hit_l;
        miss_q <= miss_l;
      end
    end

    assign hit_d[n]                      = hit_l;
    assign miss_d[n]                     = miss_l;
    assign bus.lane_active_o[n]          = act_q;
    assign bus.lane_y_o[n*CORDW +: CORDW] = y_q;
    assign bus.hit_o[n]                  = hit_q;
    assign bus.miss_o[n]                 = miss_q;
  end

  logic [2:0]         hit_n, miss_n;
  logic [SCORE_W:0]   score_sum;
  logic [4:0]         miss_sum;

  always_comb begin
    hit_n      = popcount4(hit_d);
    miss_n     = popcount4(miss_d);
    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(hit_n);
    miss_sum   = {1'b0, miss_cnt_q} + {2'b00, miss_n};
    state_d    = state_q;
    score_d    = score_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      ST_PLAY: begin
        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (miss_sum >= 5'(MAX_MISS)) begin
          miss_cnt_d = 4'(MAX_MISS);
          state_d    = ST_OVER;
        end else begin
          miss_cnt_d = miss_sum[3:0];
        end
      end
      default: begin
        if (bus.start_i) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          miss_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.score_o    = score_q;
  assign bus.miss_cnt_o = miss_cnt_q;
  assign bus.state_o    = game_state_e'(state_q);

endmodule

// File: tb/tb_ddr_lane_scheduler.sv
// Bench for ddr_lane_scheduler: fixed vectors, hand-built game sequences and
// random play, all scored against a game-rules model.
module tb_ddr_lane_scheduler;

  localparam int         CORDW        = 10;
  localparam int         SPAWN_Y      = 480;
  localparam int         TOP_Y        = 3;
  localparam int         SPEED        = 7;
  localparam int         TARGET_Y     = 40;
  localparam int         WINDOW       = 10;
  localparam int         SPAWN_FRAMES = 30;
  localparam int         MAX_MISS     = 8;
  localparam int         SCORE_W      = 8;
  localparam logic [7:0] LFSR_SEED    = 8'hA5;
  localparam int         S_IDLE = 0, S_PLAY = 1, S_OVER = 2;

  // ---------------- clock / reset ----------------
  logic clk_i    = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ddr_lane_scheduler_if #(.CORDW(CORDW), .SCORE_W(SCORE_W)) bus ();

  ddr_lane_scheduler #(
    .CORDW(CORDW), .SPAWN_Y(SPAWN_Y), .TOP_Y(TOP_Y), .SPEED(SPEED),
    .TARGET_Y(TARGET_Y), .WINDOW(WINDOW), .SPAWN_FRAMES(SPAWN_FRAMES),
    .MAX_MISS(MAX_MISS), .SCORE_W(SCORE_W), .LFSR_SEED(LFSR_SEED)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int         m_state, m_score, m_misses, m_frames;
  logic [7:0] m_lfsr;
  int         m_y [4];
  bit         m_act [4];
  logic [3:0] m_hit, m_miss;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & 8'hB8)};
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [3:0] m_active();
    logic [3:0] a;
    for (int n = 0; n < 4; n++) a[n] = m_act[n];
    return a;
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_score = 0; m_misses = 0; m_frames = 0;
    m_lfsr = LFSR_SEED; m_hit = '0; m_miss = '0;
    for (int n = 0; n < 4; n++) begin m_act[n] = 0; m_y[n] = SPAWN_Y; end
  endfunction

  function automatic void model_step(input logic fr, input logic st, input logic [3:0] pr);
    bit was [4];
    bit spawn;
    int lane;
    m_hit = '0; m_miss = '0;
    if (m_state != S_PLAY) begin
      if (st) begin
        m_state = S_PLAY; m_score = 0; m_misses = 0; m_frames = 0;
        for (int n = 0; n < 4; n++) begin m_act[n] = 0; m_y[n] = SPAWN_Y; end
      end
      return;
    end
    spawn = 0;
    if (fr) begin
      m_lfsr = lfsr_next(m_lfsr);
      m_frames++;
      if (m_frames == SPAWN_FRAMES) begin m_frames = 0; spawn = 1; end
    end
    for (int n = 0; n < 4; n++) was[n] = m_act[n];
    for (int n = 0; n < 4; n++) begin
      if (m_act[n] && pr[n]) begin
        if (iabs(m_y[n] - TARGET_Y) <= WINDOW) m_hit[n] = 1'b1;
        else m_miss[n] = 1'b1;
        m_act[n] = 0; m_y[n] = SPAWN_Y;
      end else if (m_act[n] && fr) begin
        if (m_y[n] - SPEED < TOP_Y) begin
          m_miss[n] = 1'b1; m_act[n] = 0; m_y[n] = SPAWN_Y;
        end else begin
          m_y[n] = m_y[n] - SPEED;
        end
      end
    end
    if (spawn) begin
      lane = int'(m_lfsr % 4);
      if (!was[lane]) begin m_act[lane] = 1; m_y[lane] = SPAWN_Y; end
    end
    m_score  = m_score + $countones(m_hit);
    if (m_score > 255) m_score = 255;
    m_misses = m_misses + $countones(m_miss);
    if (m_misses >= MAX_MISS) begin m_misses = MAX_MISS; m_state = S_OVER; end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int dut_y(input int n);
    return int'(bus.lane_y_o[n*CORDW +: CORDW]);
  endfunction

  task automatic check_model(input string tag);
    check({tag, " active"}, bus.lane_active_o, m_active());
    for (int n = 0; n < 4; n++) check($sformatf("%s y%0d", tag, n), dut_y(n), m_y[n]);
    check({tag, " hit"},      bus.hit_o,      m_hit);
    check({tag, " miss"},     bus.miss_o,     m_miss);
    check({tag, " score"},    bus.score_o,    m_score);
    check({tag, " miss_cnt"}, bus.miss_cnt_o, m_misses);
    check({tag, " state"},    int'(bus.state_o), m_state);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic fr, input logic st, input logic [3:0] pr, input string tag);
    bus.frame_i = fr; bus.start_i = st; bus.press_i = pr;
    @(posedge clk_i); #1;
    model_step(fr, st, pr);
    bus.frame_i = 1'b0; bus.start_i = 1'b0; bus.press_i = '0;
    check_model(tag);
  endtask

  typedef struct {
    logic       fr;
    logic       st;
    logic [3:0] pr;
    int         exp_state;
    logic [3:0] exp_act;
    int         exp_score;
    logic [3:0] exp_pulse;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int tl, ln, a, b, obs, pre, sc, found;
    logic [3:0] sv_act, mask, exp_hit, exp_miss;
    logic [4*CORDW-1:0] sv_y;
    logic fr, st;
    logic [3:0] pr;

    bus.frame_i = 1'b0; bus.start_i = 1'b0; bus.press_i = '0;
    model_reset();

    // 1. reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("reset active", bus.lane_active_o, 0);
    for (int n = 0; n < 4; n++) check($sformatf("reset y%0d", n), dut_y(n), SPAWN_Y);
    check("reset state", int'(bus.state_o), S_IDLE);
    check("reset score", bus.score_o, 0);
    check("reset miss_cnt", bus.miss_cnt_o, 0);
    check("reset pulses", {bus.hit_o, bus.miss_o}, 0);
    reset_ni = 1'b1;

    // 2. vector table: idle behaviour and start handling
    tbl[0] = '{1'b1, 1'b0, 4'h0, S_IDLE, 4'h0, 0, 4'h0};
    tbl[1] = '{1'b0, 1'b0, 4'hF, S_IDLE, 4'h0, 0, 4'h0};
    tbl[2] = '{1'b0, 1'b1, 4'h0, S_PLAY, 4'h0, 0, 4'h0};
    tbl[3] = '{1'b0, 1'b1, 4'h0, S_PLAY, 4'h0, 0, 4'h0};
    tbl[4] = '{1'b0, 1'b0, 4'hF, S_PLAY, 4'h0, 0, 4'h0};
    tbl[5] = '{1'b0, 1'b0, 4'h0, S_PLAY, 4'h0, 0, 4'h0};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].fr, tbl[i].st, tbl[i].pr, $sformatf("vec%0d", i));
      check($sformatf("vec%0d state", i), int'(bus.state_o), tbl[i].exp_state);
      check($sformatf("vec%0d active", i), bus.lane_active_o, tbl[i].exp_act);
      check($sformatf("vec%0d score", i), bus.score_o, tbl[i].exp_score);
      check($sformatf("vec%0d pulses", i), bus.hit_o | bus.miss_o, tbl[i].exp_pulse);
    end

    // 3. first spawn on the 30th frame, then scrolling
    for (int i = 0; i < SPAWN_FRAMES - 1; i++) drive(1'b1, 1'b0, 4'h0, "prespawn");
    check("prespawn active", bus.lane_active_o, 0);
    drive(1'b1, 1'b0, 4'h0, "spawn");
    tl = 0;
    for (int n = 0; n < 4; n++) if (m_act[n]) tl = n;
    check("spawn count", $countones(bus.lane_active_o), 1);
    check("spawn y", dut_y(tl), 480);
    drive(1'b1, 1'b0, 4'h0, "move1");
    check("move1 y", dut_y(tl), 473);
    drive(1'b1, 1'b0, 4'h0, "move2");
    check("move2 y", dut_y(tl), 466);

    // 4. hit at y=39
    for (int i = 0; i < 100 && m_y[tl] != 39; i++) drive(1'b1, 1'b0, 4'h0, "to39");
    check("y before hit", dut_y(tl), 39);
    drive(1'b0, 1'b0, 4'(1 << tl), "hit39");
    check("hit39 hit_o", bus.hit_o, 4'(1 << tl));
    check("hit39 score", bus.score_o, 1);
    check("hit39 lane idle", bus.lane_active_o[tl], 0);
    check("hit39 y", dut_y(tl), 480);

    // 5. bad press at y=60, and a press on an idle lane
    found = 0; ln = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      for (int n = 0; n < 4; n++) if (m_act[n] && m_y[n] == 60) begin found = 1; ln = n; end
      if (found == 0) drive(1'b1, 1'b0, 4'h0, "to60");
    end
    check("found y60", found, 1);
    pre = int'(bus.miss_cnt_o);
    drive(1'b0, 1'b0, 4'(1 << ln), "miss60");
    check("miss60 miss_o", bus.miss_o, 4'(1 << ln));
    check("miss60 hit_o", bus.hit_o, 0);
    check("miss60 miss_cnt", bus.miss_cnt_o, pre + 1);
    found = 0;
    for (int n = 0; n < 4; n++) if (!m_act[n] && found == 0) begin found = 1; ln = n; end
    if (found == 1) begin
      drive(1'b0, 1'b0, 4'(1 << ln), "idle press");
      check("idle press pulses", bus.hit_o | bus.miss_o, 0);
    end

    // 6. let arrows escape until the game ends, then freeze and restart
    pre = int'(bus.miss_cnt_o); obs = 0;
    for (int i = 0; i < 3000 && m_state != S_OVER; i++) begin
      drive(1'b1, 1'b0, 4'h0, "escape");
      obs += $countones(bus.miss_o);
    end
    check("over state", int'(bus.state_o), S_OVER);
    check("over miss_cnt", bus.miss_cnt_o, MAX_MISS);
    check("over miss pulses", (pre + obs >= MAX_MISS) ? 1 : 0, 1);
    sv_act = bus.lane_active_o; sv_y = bus.lane_y_o;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'hF, "frozen");
    check("frozen active", bus.lane_active_o, sv_act);
    check("frozen y", bus.lane_y_o, sv_y);
    check("frozen pulses", bus.hit_o | bus.miss_o, 0);
    drive(1'b0, 1'b1, 4'h0, "restart");
    check("restart state", int'(bus.state_o), S_PLAY);
    check("restart score", bus.score_o, 0);
    check("restart miss_cnt", bus.miss_cnt_o, 0);
    check("restart active", bus.lane_active_o, 0);

    // 7. two lanes pressed together with a coincident frame
    found = 0; a = 0; b = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      if (m_state != S_PLAY) drive(1'b0, 1'b1, 4'h0, "rearm");
      for (int n = 0; n < 4; n++)
        if (m_act[n] && iabs(m_y[n] - TARGET_Y) <= WINDOW) begin
          for (int k = 0; k < 4; k++) if (k != n && m_act[k] && found == 0) begin
            found = 1; a = n; b = k;
          end
        end
      if (found == 0) drive(1'b1, 1'b0, 4'h0, "to_pair");
    end
    check("found pair", found, 1);
    mask = 4'((1 << a) | (1 << b));
    exp_hit = 4'(1 << a); exp_miss = '0;
    if (iabs(m_y[b] - TARGET_Y) <= WINDOW) exp_hit[b] = 1'b1; else exp_miss[b] = 1'b1;
    sc = m_score;
    drive(1'b1, 1'b0, mask, "pair");
    check("pair hit_o", bus.hit_o, exp_hit);
    check("pair miss_o", bus.miss_o & mask, exp_miss);
    check("pair score", bus.score_o, sc + $countones(exp_hit));
    check("pair lanes idle", bus.lane_active_o & mask, 0);
    check("pair ya", dut_y(a), 480);
    check("pair yb", dut_y(b), 480);

    // 8. asynchronous reset mid-game with two lanes live
    if (m_state != S_PLAY) drive(1'b0, 1'b1, 4'h0, "rearm2");
    for (int i = 0; i < 400 && $countones(m_active()) < 2; i++) drive(1'b1, 1'b0, 4'h0, "to_two");
    check("two live", $countones(bus.lane_active_o) >= 2 ? 1 : 0, 1);
    #2 reset_ni = 1'b0;
    #1;
    check("async active", bus.lane_active_o, 0);
    check("async score", bus.score_o, 0);
    check("async state", int'(bus.state_o), S_IDLE);
    check("async pulses", bus.hit_o | bus.miss_o, 0);
    model_reset();
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    drive(1'b0, 1'b0, 4'h0, "post_reset");

    // 9. random play against the model
    drive(1'b0, 1'b1, 4'h0, "rnd_start");
    for (int i = 0; i < 4000; i++) begin
      fr = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 199) == 0);
      for (int n = 0; n < 4; n++) pr[n] = ($urandom_range(0, 11) == 0);
      drive(fr, st, pr, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
